sumador_arbiter: RTL and testbench

Round-robin controller that shares one external 16-bit add/sub datapath (sumador_16bits style: a, b, control -> result, overflow) between two requesters. It accepts a request, drives registered operands into the adder, captures the result one cycle later and returns it with a done pulse. It also keeps an 8-bit completed-operation count and a sticky overflow flag for status.

---
 rtl/sumador_arbiter.sv | 151 +++++++++++++++
 tb/tb_sumador_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sumador_arbiter.sv
// sumador_arbiter: round-robin front end that shares one external 16-bit
// add/sub datapath between two requesters. An accepted request is registered
// onto sum_a/sum_b/sum_control, the adder result is captured one cycle later,
// and a done pulse returns it to the requester that owns the operation.
// Status: wrapping completed-operation counter and sticky overflow flag.
module sumador_arbiter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             ctrl0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             ctrl1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic             busy,
    input  logic             clr_stats,
    output logic [WIDTH-1:0] sum_a,
    output logic [WIDTH-1:0] sum_b,
    output logic             sum_control,
    input  logic [WIDTH-1:0] sum_result,
    input  logic             sum_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic             prio_reg;      // requester that wins a simultaneous request
    logic             owner_reg;     // requester owning the operation in flight
    logic             win;           // arbitration winner in the current IDLE cycle
    logic             accept;        // a request is being granted this cycle
    logic [1:0]       gnt_vec;
    logic [1:0]       done_vec;

    logic [WIDTH-1:0] sum_a_reg;
    logic [WIDTH-1:0] sum_b_reg;
    logic             sum_control_reg;
    logic [WIDTH-1:0] result_reg;
    logic             overflow_reg;
    logic             ovf_sticky_reg;
    logic [CNT_W-1:0] op_count_reg;

    // Next-state and arbitration: grants are only issued from IDLE.
    always_comb begin
        state_next = state_reg;
        win        = 1'b0;
        accept     = 1'b0;
        gnt_vec    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    // Single requester wins outright; a tie goes to the pointer.
                    win        = (req0 && req1) ? prio_reg : req1;
                    accept     = 1'b1;
                    gnt_vec    = win ? 2'b10 : 2'b01;
                    state_next = CALC;
                end
            end
            CALC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-requester done pulse: asserted only in DONE for the owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_done
            assign done_vec[gi] = (state_reg == DONE) && (owner_reg == gi[0]);
        end
    endgenerate

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand launch on grant, then result capture after the adder settles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_a_reg       <= '0;
            sum_b_reg       <= '0;
            sum_control_reg <= 1'b0;
            owner_reg       <= 1'b0;
            prio_reg        <= 1'b0;
            result_reg      <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            if (accept) begin
                sum_a_reg       <= win ? a1 : a0;
                sum_b_reg       <= win ? b1 : b0;
                sum_control_reg <= win ? ctrl1 : ctrl0;
                owner_reg       <= win;
                prio_reg        <= ~win;   // the other requester wins the next tie
            end
            if (state_reg == CALC) begin
                result_reg   <= sum_result;
                overflow_reg <= sum_overflow;
            end
        end
    end

    // Status counters; a clear takes precedence over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
        end else if (clr_stats) begin
            op_count_reg   <= '0;
            ovf_sticky_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            op_count_reg   <= op_count_reg + 1'b1;
            ovf_sticky_reg <= ovf_sticky_reg | overflow_reg;
        end
    end

    assign gnt0        = gnt_vec[0];
    assign gnt1        = gnt_vec[1];
    assign done0       = done_vec[0];
    assign done1       = done_vec[1];
    assign busy        = (state_reg != IDLE);
    assign result      = result_reg;
    assign overflow    = overflow_reg;
    assign ovf_sticky  = ovf_sticky_reg;
    assign op_count    = op_count_reg;
    assign sum_a       = sum_a_reg;
    assign sum_b       = sum_b_reg;
    assign sum_control = sum_control_reg;

endmodule

// File: tb/tb_sumador_arbiter.sv
// tb_sumador_arbiter: directed bench for sumador_arbiter with a behavioural
// 16-bit add/sub datapath attached to the sum_* ports.
module tb_sumador_arbiter;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, ctrl0, ctrl1, clr_stats;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1, done0, done1, overflow, ovf_sticky, busy;
    logic [WIDTH-1:0] result, sum_a, sum_b, sum_result;
    logic [CNT_W-1:0] op_count;
    logic             sum_control, sum_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External adder: a+b or a-b with signed overflow detection.
    always_comb begin
        sum_result   = sum_control ? (sum_a - sum_b) : (sum_a + sum_b);
        sum_overflow = sum_control ?
            ((sum_a[15] != sum_b[15]) && (sum_result[15] != sum_a[15])) :
            ((sum_a[15] == sum_b[15]) && (sum_result[15] != sum_a[15]));
    end

    sumador_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .ctrl0(ctrl0),
        .req1(req1), .a1(a1), .b1(b1), .ctrl1(ctrl1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .overflow(overflow), .ovf_sticky(ovf_sticky),
        .op_count(op_count), .busy(busy), .clr_stats(clr_stats),
        .sum_a(sum_a), .sum_b(sum_b), .sum_control(sum_control),
        .sum_result(sum_result), .sum_overflow(sum_overflow)
    );

    // Advance to 2 time units after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; clr_stats = 1'b0;
        req0 = 1'b0; a0 = '0; b0 = '0; ctrl0 = 1'b0;
        req1 = 1'b0; a1 = '0; b1 = '0; ctrl1 = 1'b0;
        tick(); tick();
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_result", {16'd0, result}, 0);
        chk("rst_count", {24'd0, op_count}, 0);
        chk("rst_suma", {16'd0, sum_a}, 0);
        chk("rst_sticky", {31'd0, ovf_sticky}, 0);
        chk("rst_done", {30'd0, done1, done0}, 0);
        rst = 1'b0;

        // 5 + 3 from requester 0, request dropped in the CALC cycle
        req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0003; ctrl0 = 1'b0; #1;
        $display("op: req0 0x0005+0x0003");
        chk("t1_gnt", {30'd0, gnt1, gnt0}, 2'b01);
        chk("t1_busy_grant", {31'd0, busy}, 0);
        tick(); req0 = 1'b0; #1;
        chk("t1_calc_busy", {31'd0, busy}, 1);
        chk("t1_calc_gnt", {30'd0, gnt1, gnt0}, 0);
        chk("t1_sum_ab", {sum_a, sum_b}, {16'h0005, 16'h0003});
        chk("t1_calc_done", {30'd0, done1, done0}, 0);
        tick(); #1;
        chk("t1_done", {30'd0, done1, done0}, 2'b01);
        chk("t1_result", {15'd0, overflow, result}, {15'd0, 1'b0, 16'h0008});
        tick(); #1;
        chk("t1_after_done", {30'd0, done1, done0}, 0);
        chk("t1_count", {24'd0, op_count}, 1);

        // 0x8000 - 0x0001 from requester 1: signed overflow
        req1 = 1'b1; a1 = 16'h8000; b1 = 16'h0001; ctrl1 = 1'b1; #1;
        $display("op: req1 0x8000-0x0001");
        chk("t2_gnt", {30'd0, gnt1, gnt0}, 2'b10);
        tick(); req1 = 1'b0; #1;
        chk("t2_ctrl", {31'd0, sum_control}, 1);
        tick(); #1;
        chk("t2_done", {30'd0, done1, done0}, 2'b10);
        chk("t2_result", {15'd0, overflow, result}, {15'd0, 1'b1, 16'h7FFF});
        chk("t2_sticky_pre", {31'd0, ovf_sticky}, 0);
        tick(); #1;
        chk("t2_sticky", {31'd0, ovf_sticky}, 1);
        chk("t2_count", {24'd0, op_count}, 2);

        // 1 + 1: no overflow, sticky flag keeps its value
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; ctrl0 = 1'b0; #1;
        $display("op: req0 0x0001+0x0001");
        chk("t3_gnt", {30'd0, gnt1, gnt0}, 2'b01);
        tick(); req0 = 1'b0;
        tick(); #1;
        chk("t3_result", {15'd0, overflow, result}, {15'd0, 1'b0, 16'h0002});
        tick(); #1;
        chk("t3_sticky", {31'd0, ovf_sticky}, 1);
        chk("t3_count", {24'd0, op_count}, 3);

        // clr_stats coinciding with the DONE increment: clear wins
        req1 = 1'b1; a1 = 16'h7FFF; b1 = 16'h0001; ctrl1 = 1'b0; #1;
        $display("op: req1 0x7FFF+0x0001 with clr_stats in DONE");
        chk("t4_gnt", {30'd0, gnt1, gnt0}, 2'b10);
        tick(); req1 = 1'b0;
        tick(); clr_stats = 1'b1; #1;
        chk("t4_done", {30'd0, done1, done0}, 2'b10);
        tick(); clr_stats = 1'b0; #1;
        chk("t4_count_clr", {24'd0, op_count}, 0);
        chk("t4_sticky_clr", {31'd0, ovf_sticky}, 0);
        chk("t4_result_kept", {15'd0, overflow, result}, {15'd0, 1'b1, 16'h8000});

        // One op so the pointer favours requester 1, then reset during CALC
        req0 = 1'b1; a0 = 16'h0002; b0 = 16'h0002; #1;
        $display("op: req0 0x0002+0x0002");
        tick(); req0 = 1'b0;
        tick(); tick(); #1;
        chk("t5_count", {24'd0, op_count}, 1);
        req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0001; #1;
        $display("op: req0 0x0010+0x0001 aborted by reset in CALC");
        chk("t5_gnt", {30'd0, gnt1, gnt0}, 2'b01);
        tick(); req0 = 1'b0; rst = 1'b1; #1;
        chk("t5_calc_busy", {31'd0, busy}, 1);
        tick(); rst = 1'b0; #1;
        chk("t5_rst_busy", {31'd0, busy}, 0);
        chk("t5_rst_done", {30'd0, done1, done0}, 0);
        chk("t5_rst_result", {16'd0, result}, 0);
        chk("t5_rst_count", {24'd0, op_count}, 0);

        // Both requests held: grants alternate 0,1,0,1 starting with 0
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0111; ctrl0 = 1'b0;
        req1 = 1'b1; a1 = 16'h0100; b1 = 16'h0001; ctrl1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic owner;
            owner = k[0];
            #1;
            $display("op: dual request round %0d, expect owner %0d", k, owner);
            chk("rr_gnt", {30'd0, gnt1, gnt0}, owner ? 2'b10 : 2'b01);
            chk("rr_busy_grant", {31'd0, busy}, 0);
            tick(); #1;
            chk("rr_calc", {30'd0, gnt1, gnt0, busy}, 3'b001);
            tick(); #1;
            chk("rr_done", {30'd0, done1, done0}, owner ? 2'b10 : 2'b01);
            chk("rr_result", {16'd0, result}, owner ? 16'h00FF : 16'h1345);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;

        // 256 back-to-back ops from a freshly reset counter: wraps to 0
        rst = 1'b1;
        tick(); rst = 1'b0;
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; ctrl0 = 1'b0;
        $display("op: 256 back-to-back req0 operations");
        for (int k = 1; k <= 256; k++) begin
            tick(); tick(); #1;
            if (k == 1 || k == 256) chk("wrap_done", {31'd0, done0}, 1);
            tick(); #1;
            if (k == 1)   chk("wrap_count_1", {24'd0, op_count}, 1);
            if (k == 255) chk("wrap_count_255", {24'd0, op_count}, 8'hFF);
            if (k == 256) chk("wrap_count_256", {24'd0, op_count}, 8'h00);
        end
        req0 = 1'b0;
        chk("wrap_result", {16'd0, result}, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
